// File: rtl/csk_pkg.sv
// csk_pkg: shared constants and types for the sequential carry-skip subtractor.
//   CSK_WIDTH       default operand/result width in bits
//   CSK_BLK         default bits handled per cycle (one carry-skip block)
//   CSK_NBLK        number of blocks per operation
//   csk_sub_state_t control FSM states
//   csk_blk_idx_t   block index type for the default configuration
package csk_pkg;

    localparam int unsigned CSK_WIDTH = 25;
    localparam int unsigned CSK_BLK   = 5;
    localparam int unsigned CSK_NBLK  = CSK_WIDTH / CSK_BLK;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } csk_sub_state_t;

    typedef logic [$clog2(CSK_NBLK)-1:0] csk_blk_idx_t;

endpackage

// File: rtl/csk_sub_block5.sv
// csk_sub_block5: combinational BLK-bit carry-skip block.
//   a    [BLK-1:0] minuend slice
//   nb   [BLK-1:0] inverted subtrahend slice
//   cin            carry into the block
//   s    [BLK-1:0] sum slice
//   cout           carry out of the block (skip-muxed)
//   P              block propagate: every bit position propagates
module csk_sub_block5 #(
    parameter int unsigned BLK = 5
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] nb,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           P
);

    logic [BLK:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, nb} + {{BLK{1'b0}}, cin};
        s    = sum[BLK-1:0];
        P    = &(a ^ nb);
        // When the whole block propagates, the incoming carry bypasses the
        // ripple chain; the result is identical to the ripple carry.
        cout = P ? cin : sum[BLK];
    end

endmodule

// File: rtl/csk_subtractor_seq.sv
// csk_subtractor_seq: sequential signed subtractor, diff = A + ~B + 1,
// processed one BLK-bit carry-skip block per clock.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   A, B    [WIDTH-1:0]  signed minuend / subtrahend, sampled at accept
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   diff    [WIDTH-1:0]  signed difference, held through DONE
//   overflow             signed overflow of A - B
// Build option: define CSK_SUB_SAT_EN to clamp diff to the representable
// extreme on overflow (overflow is still reported).
module csk_subtractor_seq
    import csk_pkg::*;
#(
    parameter int unsigned WIDTH = CSK_WIDTH,
    parameter int unsigned BLK   = CSK_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             overflow
);

    localparam int unsigned NBLK = WIDTH / BLK;
    localparam int unsigned KW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NBLK - 1);

    csk_sub_state_t   state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [BLK-1:0]   blk_a;
    logic [BLK-1:0]   blk_nb;
    logic [BLK-1:0]   blk_s;
    logic             blk_cout;
    logic             blk_p;

    always_comb begin
        blk_a  = a_q[k_q*BLK +: BLK];
        blk_nb = nb_q[k_q*BLK +: BLK];
    end

    csk_sub_block5 #(
        .BLK (BLK)
    ) u_blk (
        .a    (blk_a),
        .nb   (blk_nb),
        .cin  (c_q),
        .s    (blk_s),
        .cout (blk_cout),
        .P    (blk_p)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        nb_d    = nb_q;
        c_d     = c_q;
        diff_d  = diff_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    nb_d    = ~B;
                    c_d     = 1'b1;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[k_q*BLK +: BLK] = blk_s;
                c_d = blk_cout;
                k_d = k_q + 1'b1;
                if (k_q == LAST_K) begin
                    state_d = DONE;
                    // Operand signs differ exactly when A and ~B share a sign
                    // bit; the result sign comes from the final block's MSB.
                    ovf_d = (a_q[WIDTH-1] == nb_q[WIDTH-1]) &
                            (blk_s[BLK-1] != a_q[WIDTH-1]);
`ifdef CSK_SUB_SAT_EN
                    if (ovf_d) begin
                        diff_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            nb_q        <= '0;
            c_q         <= 1'b0;
            diff_q      <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            nb_q        <= nb_d;
            c_q         <= c_d;
            diff_q      <= diff_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign overflow  = ovf_q;

endmodule
